alu_result_buffer: RTL and testbench
====================================

Name: alu_result_buffer

Overview:
Downstream stage of the ALU. Captures the ALU result stream (out/out_valid), which has no backpressure, into a DEPTH-entry FIFO. Presents results to the consumer over a valid/ready interface. Raises almost_full early enough that the issuer can stop driving ALU in_valid before results in the 2-cycle ALU pipeline are lost. Flags any dropped result with a sticky overflow bit.

Parameters:
WIDTH, 6, result width; must equal the ALU WIDTH.
DEPTH, 8, FIFO entries; power of 2, >= 4.
AFULL_MARGIN, 2, free slots reserved for ALU in-flight results; 1 <= AFULL_MARGIN < DEPTH.

Ports:
clk  input  1  clock, rising edge
rst  input  1  reset, asynchronous, active-high
in_data  input  WIDTH  ALU result (ALU out)
in_valid  input  1  ALU out_valid; push request, no backpressure
out_data  output  WIDTH  head-of-FIFO result
out_valid  output  1  head entry valid
out_ready  input  1  consumer accepts head this cycle
count  output  $clog2(DEPTH+1)  occupied entries
almost_full  output  1  count >= DEPTH - AFULL_MARGIN
overflow  output  1  sticky: a push was dropped
clr_overflow  input  1  synchronous clear of overflow

Behaviour:
- Reset (async assert, sync-safe deassert on clk): wr_ptr=0, rd_ptr=0, count=0, overflow=0. Outputs: out_valid=0, out_data=0, almost_full=0. Storage array is not reset.
- Storage: DEPTH x WIDTH register array. Pointers are $clog2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
- pop = out_valid & out_ready. out_ready while out_valid=0 has no effect.
- push_ok = in_valid & (count < DEPTH | pop).
- On push_ok: mem[wr_ptr] <= in_data, wr_ptr++.
- On pop: rd_ptr++.
- count update: +1 on push_ok only, -1 on pop only, unchanged on both or neither.
- Full and pop in the same cycle: push is accepted, count stays DEPTH, no overflow.
- Empty and push in the same cycle: no pop (out_valid=0). Data appears at out_valid/out_data on the next cycle. Write-to-read latency is 1 cycle; there is no combinational in-to-out path.
- Show-ahead output: out_valid = (count != 0). out_data = mem[rd_ptr] when out_valid=1, else 0.
- Overflow: in_valid while count==DEPTH and no pop drops in_data. Pointers and count are unchanged; overflow <= 1 the next cycle.
- overflow stays 1 until a clr_overflow cycle. If clr_overflow and a new drop occur in the same cycle, set wins and overflow stays 1.
- almost_full is decoded combinationally from the count register only, never from in_valid or out_ready. Issuer contract: while almost_full=1, drive no new ALU in_valid. Given ALU latency 2 and AFULL_MARGIN >= 2, this guarantees no overflow.
- count and overflow reflect the registered state. Nothing feeds back combinationally from out_ready to out_valid.
- Reset mid-stream: all contents are discarded immediately. out_valid=0 and count=0 while rst=1. in_valid is ignored while rst=1.
- No X on any output after reset, including out_data when empty.

Test Plan:
(WIDTH=6, DEPTH=8, AFULL_MARGIN=2)

1. Reset, then idle -> out_valid=0, out_data=0, count=0, almost_full=0, overflow=0.
2. Push 0x01..0x05 on 5 consecutive cycles with out_ready=0, then out_ready=1 -> count reaches 5; out_data sequence 0x01..0x05 in order, one per cycle; count returns to 0; out_valid drops the cycle after the last pop.
3. Push 6 entries with no pop -> almost_full=1 exactly when count=6 (not at 5). Pop one -> almost_full=0 when count=5.
4. Fill to 8, then push 0x3F with out_ready=0 -> 0x3F dropped, count=8, overflow=1 next cycle. Assert clr_overflow together with another dropped push -> overflow stays 1. Clear alone -> overflow=0.
5. Fill to 8, then push 0x2A with out_ready=1 in the same cycle -> push accepted, count=8, overflow=0. Drain order ends with 0x2A. Run more than 16 pushes total so both pointers wrap.
6. Load 4 entries, assert rst mid-drain with out_ready=1 -> out_valid=0 and count=0 asynchronously. After release, the next push of 0x15 appears as out_data=0x15 with count=1.

Source files
------------

// File: rtl/alu_result_buffer.sv
// rtl/alu_result_buffer.sv - show-ahead FIFO capturing the ALU result stream with almost_full and sticky overflow
module alu_result_buffer #(
   parameter int WIDTH        = 6,
   parameter int DEPTH        = 8,
   parameter int AFULL_MARGIN = 2
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [WIDTH-1:0]           in_data,
   input  logic                       in_valid,
   output logic [WIDTH-1:0]           out_data,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output logic                       almost_full,
   output logic                       overflow,
   input  logic                       clr_overflow
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);
   localparam logic [CW-1:0] FULL_LEVEL  = CW'(DEPTH);
   localparam logic [CW-1:0] AFULL_LEVEL = CW'(DEPTH - AFULL_MARGIN);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic             pop;
   logic             push_ok;
   logic             drop;

   // Handshake decode; pushes are gated off while reset is held so nothing lands in storage.
   always_comb begin
      pop     = out_valid & out_ready;
      push_ok = in_valid & ~rst & ((count != FULL_LEVEL) | pop);
      drop    = in_valid & ~rst & (count == FULL_LEVEL) & ~pop;
   end

   // Show-ahead head and status flags come only from registered state, never from the handshake inputs.
   always_comb begin
      out_valid   = (count != '0);
      out_data    = out_valid ? mem[rd_ptr] : '0;
      almost_full = (count >= AFULL_LEVEL);
   end

   // Storage array is deliberately left unreset; the head is masked to zero whenever the FIFO is empty.
   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem[wr_ptr] <= in_data;
      end
   end

   // Pointers and occupancy; pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok) begin
            wr_ptr <= wr_ptr + PW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PW'(1);
         end
         if (push_ok && !pop) begin
            count <= count + CW'(1);
         end else if (pop && !push_ok) begin
            count <= count - CW'(1);
         end
      end
   end

   // Sticky overflow: a new drop takes priority over a same-cycle clear.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         overflow <= 1'b0;
      end else if (drop) begin
         overflow <= 1'b1;
      end else if (clr_overflow) begin
         overflow <= 1'b0;
      end
   end

endmodule

// File: tb/tb_alu_result_buffer.sv
// tb/tb_alu_result_buffer.sv - directed scoreboard bench for alu_result_buffer
module tb_alu_result_buffer;

   logic       clk;
   logic       rst;
   logic [5:0] in_data;
   logic       in_valid;
   logic [5:0] out_data;
   logic       out_valid;
   logic       out_ready;
   logic [3:0] count;
   logic       almost_full;
   logic       overflow;
   logic       clr_overflow;

   int errors = 0;
   int checks = 0;

   logic [5:0] exp_q[$];
   logic       ovf_m;

   alu_result_buffer #(.WIDTH(6), .DEPTH(8), .AFULL_MARGIN(2)) dut (
      .clk          (clk),
      .rst          (rst),
      .in_data      (in_data),
      .in_valid     (in_valid),
      .out_data     (out_data),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .count        (count),
      .almost_full  (almost_full),
      .overflow     (overflow),
      .clr_overflow (clr_overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_state();
      logic [5:0] head;
      head = (exp_q.size() != 0) ? exp_q[0] : 6'h00;
      chk("count", {4'h0, count}, 8'(exp_q.size()));
      chk("out_valid", {7'h0, out_valid}, {7'h0, exp_q.size() != 0});
      chk("out_data", {2'h0, out_data}, {2'h0, head});
      chk("almost_full", {7'h0, almost_full}, {7'h0, exp_q.size() >= 6});
      chk("overflow", {7'h0, overflow}, {7'h0, ovf_m});
   endtask

   // Drive one cycle of stimulus, update the model, then check the registered result after the edge.
   task automatic cycle(input logic iv, input logic [5:0] d, input logic rdy, input logic clr);
      logic pop_m;
      logic full_m;
      in_valid     = iv;
      in_data      = d;
      out_ready    = rdy;
      clr_overflow = clr;
      pop_m  = rdy && (exp_q.size() != 0);
      full_m = (exp_q.size() == 8);
      if (pop_m) void'(exp_q.pop_front());
      if (iv && (!full_m || pop_m)) exp_q.push_back(d);
      if (iv && full_m && !pop_m) ovf_m = 1'b1;
      else if (clr) ovf_m = 1'b0;
      @(posedge clk);
      #1;
      check_state();
   endtask

   task automatic drain();
      for (int i = 0; i < 12; i++) begin
         if (exp_q.size() != 0) cycle(1'b0, 6'h00, 1'b1, 1'b0);
      end
   endtask

   initial begin
      rst          = 1'b1;
      in_valid     = 1'b0;
      in_data      = 6'h00;
      out_ready    = 1'b0;
      clr_overflow = 1'b0;
      ovf_m        = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      @(posedge clk);
      #1;
      check_state();

      // push 0x01..0x05 without popping, then drain in order
      for (int i = 1; i <= 5; i++) cycle(1'b1, 6'(i), 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) cycle(1'b0, 6'h00, 1'b1, 1'b0);
      cycle(1'b0, 6'h00, 1'b1, 1'b0);

      // almost_full threshold at six entries, releases at five
      for (int i = 0; i < 6; i++) cycle(1'b1, 6'(8'h10 + i), 1'b0, 1'b0);
      cycle(1'b0, 6'h00, 1'b1, 1'b0);
      drain();

      // overflow: drop while full, set beats clear, then clear alone
      for (int i = 0; i < 8; i++) cycle(1'b1, 6'(8'h20 + i), 1'b0, 1'b0);
      cycle(1'b1, 6'h3F, 1'b0, 1'b0);
      cycle(1'b1, 6'h3E, 1'b0, 1'b1);
      cycle(1'b0, 6'h00, 1'b0, 1'b1);
      drain();

      // full with simultaneous pop accepts the push; drain ends with 0x2A
      for (int i = 0; i < 8; i++) cycle(1'b1, 6'(8'h30 + i), 1'b0, 1'b0);
      cycle(1'b1, 6'h2A, 1'b1, 1'b0);
      drain();

      // random streaming traffic across many pointer wraps
      for (int i = 0; i < 40; i++) begin
         cycle(1'($urandom_range(0, 1)), 6'($urandom), 1'($urandom_range(0, 1)), 1'b0);
      end
      drain();
      if (ovf_m) cycle(1'b0, 6'h00, 1'b0, 1'b1);

      // asynchronous reset mid-drain, then a single push after release
      for (int i = 0; i < 4; i++) cycle(1'b1, 6'(8'h08 + i), 1'b0, 1'b0);
      cycle(1'b0, 6'h00, 1'b1, 1'b0);
      rst = 1'b1;
      #1;
      exp_q.delete();
      ovf_m = 1'b0;
      chk("rst_async_out_valid", {7'h0, out_valid}, 8'h00);
      chk("rst_async_count", {4'h0, count}, 8'h00);
      in_valid = 1'b1;
      in_data  = 6'h11;
      @(posedge clk);
      #1;
      check_state();
      in_valid = 1'b0;
      rst      = 1'b0;
      cycle(1'b1, 6'h15, 1'b0, 1'b0);
      chk("post_rst_data", {2'h0, out_data}, 8'h15);
      cycle(1'b0, 6'h00, 1'b1, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
